top_fdct_mac_pipe: RTL and testbench
====================================

Name: top_fdct_mac_pipe

Overview:
- Parametrised, pipelined multiply / multiply-accumulate unit for the FDCT datapath.
- Generalises the fixed single-stage 16s×13ns multiplier:
  - configurable operand widths, signedness and pipeline depth
  - valid/clock-enable pipelining
  - optional dot-product accumulate mode for row/column DCT sums
- Sits between the coefficient ROM/transpose buffer and the DCT output rounding stage.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, multiplier pipeline depth, ≥1.
- din0_WIDTH, 16, operand A width.
- din1_WIDTH, 13, operand B width.
- dout_WIDTH, 29, result / accumulator width.
- A_SIGNED, 1, 1 = din0 signed, 0 = unsigned.
- B_SIGNED, 0, 1 = din1 signed, 0 = unsigned (zero-extended by one bit before the signed multiply).
- MODE, 0, 0 = multiply only, 1 = accumulate.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register except under reset.
- in_valid  in  1  input beat valid.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- in_first  in  1  MODE1: beat starts a new sum; ignored in MODE0.
- in_last  in  1  MODE1: beat ends the sum; ignored in MODE0.
- out_valid  out  1  dout valid, one-cycle pulse per result.
- dout  out  dout_WIDTH  product (MODE0) or sum (MODE1).
- out_last  out  1  MODE1: qualifies dout as final sum; always 0 in MODE0.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge, regardless of ce):
  - all pipeline valids, out_valid, out_last = 0; dout = 0; accumulator = 0.
  - In-flight beats are discarded; there is no partial output after reset.
- Product width PROD_W = din0_WIDTH + din1_WIDTH; product is exact in PROD_W bits for every signedness combination.
- Product is sign-extended (if either operand is signed) or zero-extended to dout_WIDTH. If dout_WIDTH < PROD_W, the LSBs are kept (wrap).
- Pipeline:
  - Operands are registered on the input stage, then NUM_STAGE-1 product register stages follow.
  - The valid bit travels alongside the data; a beat advances only on edges with ce=1.
- MODE0:
  - out_valid=1 and dout = product exactly NUM_STAGE ce-enabled edges after the accepting edge.
  - Throughput is one beat per enabled cycle; no backpressure beyond ce.
- MODE1: one extra accumulator stage; latency NUM_STAGE+1.
  - Per valid product: acc_next = product if first-flag, or if the previous beat was last; otherwise acc + product. Addition is modulo 2^dout_WIDTH.
  - out_valid and out_last assert only for the beat tagged in_last; dout = final sum. Non-last beats produce no out_valid; dout holds its last value.
  - After a last beat, the accumulator implicitly restarts, so an untagged next beat starts from 0.
  - in_first and in_last on the same beat: dout = that product.
  - in_first mid-sum discards the partial sum with no output.
- ce=0: outputs and all state hold; out_valid stays at its previous value but represents no new result. A consumer must sample on ce=1 edges only.
- in_valid=0 beats never touch the accumulator.

Optional Feature:
- TOP_FDCT_MAC_SAT_EN.
- Defined:
  - Every narrowing to dout_WIDTH (product truncation, accumulator add) saturates to [−2^(dout_WIDTH−1), 2^(dout_WIDTH−1)−1] when signed, or [0, 2^dout_WIDTH−1] when both operands are unsigned.
  - Adds output sat_flag (1 bit), registered alongside out_valid, set when any contributing operation clamped.
- Undefined: pure wrap-around, no sat_flag port.

Decomposition:
- Package top_fdct_mac_pkg:
  - MODE_MUL/MODE_ACC constants.
  - Function computing PROD_W.
  - Saturation bound functions.
- One sub-module top_fdct_mac_pipe_mul:
  - Registered signed/unsigned multiplier of depth NUM_STAGE with valid/first/last sideband.
  - Accumulator and saturation live in the top.

Test Plan:
- MODE0, defaults: din0=−3, din1=8191, in_valid one cycle → out_valid pulses exactly 2 cycles later, dout=−24573.
- MODE0: 8 back-to-back beats din0=k, din1=k (k=0..7) → 8 consecutive out_valid cycles, dout=0,1,4,…,49 in order.
- MODE1, NUM_STAGE=2: din0=1..8, din1=100, in_first on beat 0, in_last on beat 7 → one out_valid with out_last, dout=3600, latency 3 after beat 7.
- MODE1 with ce=0 for 3 cycles mid-stream, same stimulus → identical single result 3600, no extra or duplicate out_valid.
- Reset asserted for 1 cycle after beat 4 of a sum, then new sum of din0=2,din1=5 ×2 beats (first/last tagged) → out_valid 0 in cycle after reset, next dout=20.
- TOP_FDCT_MAC_SAT_EN, MODE1: 8 beats din0=32767, din1=8191 → dout=268435455 (2^28−1), sat_flag=1. Without the macro: dout = wrapped sum mod 2^29 as signed.

Source files
------------

// File: rtl/top_fdct_mac_pkg.sv
// Shared constants, sideband type and sizing helpers for the FDCT multiply/accumulate pipeline.
package top_fdct_mac_pkg;

   localparam int MODE_MUL = 0;
   localparam int MODE_ACC = 1;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } side_t;

   function automatic int prodWidth(input int aWidth, input int bWidth);
      return aWidth + bWidth;
   endfunction

   // Bounds are carried in 64 bits, so result widths up to 62 bits are supported.
   function automatic longint satHi(input int width, input bit isSigned);
      if (isSigned)
         return (64'sd1 <<< (width - 1)) - 64'sd1;
      return (64'sd1 <<< width) - 64'sd1;
   endfunction

   function automatic longint satLo(input int width, input bit isSigned);
      if (isSigned)
         return -(64'sd1 <<< (width - 1));
      return 64'sd0;
   endfunction

endpackage

// File: rtl/top_fdct_mac_pipe_mul.sv
// Registered multiplier: one operand stage plus NUM_STAGE-1 product stages, with
// valid/first/last sideband travelling alongside the data.
module top_fdct_mac_pipe_mul
   import top_fdct_mac_pkg::*;
#(
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 13,
   parameter int A_SIGNED   = 1,
   parameter int B_SIGNED   = 0,
   parameter int MUL_W      = 30
) (
   input  logic                    i_clk,
   input  logic                    i_rstN,
   input  logic                    i_ce,
   input  side_t                   i_side,
   input  logic [din0_WIDTH-1:0]   i_din0,
   input  logic [din1_WIDTH-1:0]   i_din1,
   output side_t                   o_side,
   output logic signed [MUL_W-1:0] o_prod
);

   logic signed [din0_WIDTH:0] r_opA;
   logic signed [din1_WIDTH:0] r_opB;
   side_t                      r_side0;
   logic signed [MUL_W-1:0]    w_aExt;
   logic signed [MUL_W-1:0]    w_bExt;
   logic signed [MUL_W-1:0]    w_prod;

   // Each operand gains one bit so a single signed multiply covers every signedness mix.
   always_ff @(posedge i_clk) begin
      if (!i_rstN) begin
         r_opA   <= '0;
         r_opB   <= '0;
         r_side0 <= '0;
      end else if (i_ce) begin
         r_opA   <= (A_SIGNED != 0) ? {i_din0[din0_WIDTH-1], i_din0} : {1'b0, i_din0};
         r_opB   <= (B_SIGNED != 0) ? {i_din1[din1_WIDTH-1], i_din1} : {1'b0, i_din1};
         r_side0 <= i_side;
      end
   end

   assign w_aExt = {{(MUL_W - din0_WIDTH - 1){r_opA[din0_WIDTH]}}, r_opA};
   assign w_bExt = {{(MUL_W - din1_WIDTH - 1){r_opB[din1_WIDTH]}}, r_opB};
   assign w_prod = w_aExt * w_bExt;

   generate
      if (NUM_STAGE == 1) begin : g_noProdReg
         assign o_prod = w_prod;
         assign o_side = r_side0;
      end else begin : g_prodReg
         logic signed [MUL_W-1:0] r_prodPipe [1:NUM_STAGE-1];
         side_t                   r_sidePipe [1:NUM_STAGE-1];

         always_ff @(posedge i_clk) begin
            if (!i_rstN) begin
               for (int i = 1; i < NUM_STAGE; i++) begin
                  r_prodPipe[i] <= '0;
                  r_sidePipe[i] <= '0;
               end
            end else if (i_ce) begin
               r_prodPipe[1] <= w_prod;
               r_sidePipe[1] <= r_side0;
               for (int i = 2; i < NUM_STAGE; i++) begin
                  r_prodPipe[i] <= r_prodPipe[i-1];
                  r_sidePipe[i] <= r_sidePipe[i-1];
               end
            end
         end

         assign o_prod = r_prodPipe[NUM_STAGE-1];
         assign o_side = r_sidePipe[NUM_STAGE-1];
      end
   endgenerate

endmodule

// File: rtl/top_fdct_mac_pipe.sv
// Pipelined FDCT multiply / multiply-accumulate unit. Optional saturation with a
// sat_flag output is enabled by defining TOP_FDCT_MAC_SAT_EN; otherwise results wrap.
module top_fdct_mac_pipe
   import top_fdct_mac_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 13,
   parameter int dout_WIDTH = 29,
   parameter int A_SIGNED   = 1,
   parameter int B_SIGNED   = 0,
   parameter int MODE       = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  out_last
`ifdef TOP_FDCT_MAC_SAT_EN
   ,
   output logic                  sat_flag
`endif
);

   localparam int PROD_W           = prodWidth(din0_WIDTH, din1_WIDTH);
   localparam int MUL_W            = PROD_W + 1;
   localparam int EXT_W            = ((MUL_W > dout_WIDTH) ? MUL_W : dout_WIDTH) + 2;
   localparam bit SIGNED_OUT       = (A_SIGNED != 0) || (B_SIGNED != 0);
   localparam int unusedInstanceId = ID;

`ifdef TOP_FDCT_MAC_SAT_EN
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(satHi(dout_WIDTH, SIGNED_OUT));
   localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(satLo(dout_WIDTH, SIGNED_OUT));
`endif

   function automatic logic signed [EXT_W-1:0] extendOut(input logic [dout_WIDTH-1:0] v);
      if (SIGNED_OUT)
         return {{(EXT_W - dout_WIDTH){v[dout_WIDTH-1]}}, v};
      return {{(EXT_W - dout_WIDTH){1'b0}}, v};
   endfunction

   // Result is {clamped, value}; without saturation the LSBs are simply kept.
   function automatic logic [dout_WIDTH:0] narrowOut(input logic signed [EXT_W-1:0] v);
`ifdef TOP_FDCT_MAC_SAT_EN
      if (v > SAT_HI)
         return {1'b1, SAT_HI[dout_WIDTH-1:0]};
      if (v < SAT_LO)
         return {1'b1, SAT_LO[dout_WIDTH-1:0]};
      return {1'b0, v[dout_WIDTH-1:0]};
`else
      return {1'b0, v[dout_WIDTH-1:0]};
`endif
   endfunction

   side_t                   w_inSide;
   side_t                   w_mulSide;
   logic signed [MUL_W-1:0] w_mulProd;
   logic signed [EXT_W-1:0] w_prodWide;
   logic [dout_WIDTH:0]     w_prodNarrow;
   logic [dout_WIDTH-1:0]   w_prodVal;
   logic                    w_prodClamp;

   assign w_inSide = {in_valid, in_first, in_last};

   top_fdct_mac_pipe_mul #(
      .NUM_STAGE  (NUM_STAGE),
      .din0_WIDTH (din0_WIDTH),
      .din1_WIDTH (din1_WIDTH),
      .A_SIGNED   (A_SIGNED),
      .B_SIGNED   (B_SIGNED),
      .MUL_W      (MUL_W)
   ) u_mul (
      .i_clk  (ap_clk),
      .i_rstN (ap_rst_n),
      .i_ce   (ce),
      .i_side (w_inSide),
      .i_din0 (din0),
      .i_din1 (din1),
      .o_side (w_mulSide),
      .o_prod (w_mulProd)
   );

   // The multiplier output is exact and signed, so sign extension is right for every mix.
   assign w_prodWide   = {{(EXT_W - MUL_W){w_mulProd[MUL_W-1]}}, w_mulProd};
   assign w_prodNarrow = narrowOut(w_prodWide);
   assign w_prodVal    = w_prodNarrow[dout_WIDTH-1:0];
   assign w_prodClamp  = w_prodNarrow[dout_WIDTH];

   generate
      if (MODE == MODE_ACC) begin : g_acc
         logic [dout_WIDTH-1:0] r_acc;
         logic [dout_WIDTH-1:0] r_dout;
         logic                  r_restart;
         logic                  r_outValid;
         logic                  r_outLast;
         logic                  w_startNew;
         logic signed [EXT_W-1:0] w_sumWide;
         logic [dout_WIDTH:0]   w_sumNarrow;
         logic [dout_WIDTH-1:0] w_accNext;

         // A sum restarts on an explicit first tag or on the beat after a last tag.
         assign w_startNew  = w_mulSide.first | r_restart;
         assign w_sumWide   = (w_startNew ? '0 : extendOut(r_acc)) + extendOut(w_prodVal);
         assign w_sumNarrow = narrowOut(w_sumWide);
         assign w_accNext   = w_sumNarrow[dout_WIDTH-1:0];

         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               r_acc      <= '0;
               r_dout     <= '0;
               r_restart  <= 1'b1;
               r_outValid <= 1'b0;
               r_outLast  <= 1'b0;
            end else if (ce) begin
               r_outValid <= w_mulSide.valid & w_mulSide.last;
               r_outLast  <= w_mulSide.valid & w_mulSide.last;
               if (w_mulSide.valid) begin
                  r_acc     <= w_accNext;
                  r_restart <= w_mulSide.last;
                  if (w_mulSide.last)
                     r_dout <= w_accNext;
               end
            end
         end

         assign out_valid = r_outValid;
         assign out_last  = r_outLast;
         assign dout      = r_dout;

`ifdef TOP_FDCT_MAC_SAT_EN
         logic r_sticky;
         logic r_satFlag;
         logic w_stickyNext;

         // Any clamp anywhere in the sum marks the final result.
         assign w_stickyNext = (~w_startNew & r_sticky) | w_prodClamp | w_sumNarrow[dout_WIDTH];

         always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
               r_sticky  <= 1'b0;
               r_satFlag <= 1'b0;
            end else if (ce && w_mulSide.valid) begin
               r_sticky <= w_stickyNext;
               if (w_mulSide.last)
                  r_satFlag <= w_stickyNext;
            end
         end

         assign sat_flag = r_satFlag;
`else
         logic w_unusedClamp;
         assign w_unusedClamp = w_prodClamp ^ w_sumNarrow[dout_WIDTH];
`endif
      end else begin : g_mul
         logic w_unusedSide;
         assign w_unusedSide = w_mulSide.first ^ w_mulSide.last;

         assign out_valid = w_mulSide.valid;
         assign out_last  = 1'b0;
         assign dout      = w_prodVal;

`ifdef TOP_FDCT_MAC_SAT_EN
         assign sat_flag = w_prodClamp;
`else
         logic w_unusedClamp;
         assign w_unusedClamp = w_prodClamp;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_top_fdct_mac_pipe.sv
// Testbench for top_fdct_mac_pipe: a MODE0 and a MODE1 instance share one stimulus stream
// and are compared every cycle against a beat-level reference model.
module tb_top_fdct_mac_pipe;

   localparam int NS = 2;
   localparam int DW = 29;

   typedef struct {
      bit     valid;
      longint prod;
      bit     first;
      bit     last;
   } beat_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ce;
   logic        in_valid;
   logic        in_first;
   logic        in_last;
   logic [15:0] din0;
   logic [12:0] din1;

   logic          mulValid, mulLast, accValid, accLast;
   logic [DW-1:0] mulDout, accDout;
`ifdef TOP_FDCT_MAC_SAT_EN
   logic          mulSat, accSat;
`endif

   int     vecCount;
   int     missCount;
   bit     checkEn;
   beat_t  hist[$];
   longint mAcc;
   bit     mRestart;
   bit     mSticky;
   bit     expMulValid;
   longint expMulDout;
   bit     expMulSat;
   bit     expAccValid;
   longint expAccDout;
   bit     expAccSat;

   always #5 ap_clk = ~ap_clk;

   top_fdct_mac_pipe #(.NUM_STAGE(NS), .MODE(0)) dutMul (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .ce        (ce),
      .in_valid  (in_valid),
      .din0      (din0),
      .din1      (din1),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (mulValid),
      .dout      (mulDout),
      .out_last  (mulLast)
`ifdef TOP_FDCT_MAC_SAT_EN
      ,
      .sat_flag  (mulSat)
`endif
   );

   top_fdct_mac_pipe #(.NUM_STAGE(NS), .MODE(1)) dutAcc (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .ce        (ce),
      .in_valid  (in_valid),
      .din0      (din0),
      .din1      (din1),
      .in_first  (in_first),
      .in_last   (in_last),
      .out_valid (accValid),
      .dout      (accDout),
      .out_last  (accLast)
`ifdef TOP_FDCT_MAC_SAT_EN
      ,
      .sat_flag  (accSat)
`endif
   );

   function automatic longint wrapOut(input longint v);
      longint m;
      m = v & ((64'sd1 <<< DW) - 64'sd1);
      if (m >= (64'sd1 <<< (DW - 1)))
         m = m - (64'sd1 <<< DW);
      return m;
   endfunction

   // Reference narrowing of an exact value to the signed DW-bit result range.
   function automatic void narrowRef(input longint v, output longint r, output bit clamped);
`ifdef TOP_FDCT_MAC_SAT_EN
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (DW - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (DW - 1));
      clamped = (v > hi) || (v < lo);
      r = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
      clamped = 1'b0;
      r = wrapOut(v);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [15:0] a, input logic [12:0] b,
                                input bit f, input bit l, input bit c);
      @(negedge ap_clk);
      in_valid = v;
      din0     = a;
      din1     = b;
      in_first = f;
      in_last  = l;
      ce       = c;
   endtask

   task automatic countPulses(input int cycles, output int pulses, output longint lastVal);
      pulses  = 0;
      lastVal = 0;
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);
         if (accValid) begin
            pulses++;
            lastVal = longint'($signed(accDout));
         end
      end
   endtask

   // Beat-level reference: beats accepted on enabled edges emerge NS (product) or
   // NS+1 (sum) enabled edges later.
   always @(posedge ap_clk) begin
      beat_t  b;
      longint pv;
      longint sv;
      bit     pc;
      bit     sc;
      bit     start;
      if (!ap_rst_n) begin
         hist.delete();
         mAcc        = 0;
         mRestart    = 1'b1;
         mSticky     = 1'b0;
         expMulValid = 1'b0;
         expMulDout  = 0;
         expMulSat   = 1'b0;
         expAccValid = 1'b0;
         expAccDout  = 0;
         expAccSat   = 1'b0;
      end else if (ce) begin
         b.valid = in_valid;
         b.prod  = longint'($signed(din0)) * longint'(din1);
         b.first = in_first;
         b.last  = in_last;
         hist.push_back(b);
         expMulValid = 1'b0;
         if (hist.size() >= NS) begin
            b = hist[hist.size() - NS];
            narrowRef(b.prod, pv, pc);
            expMulValid = b.valid;
            expMulDout  = pv;
            expMulSat   = pc;
         end
         expAccValid = 1'b0;
         if (hist.size() >= NS + 1) begin
            b = hist[hist.size() - NS - 1];
            expAccValid = b.valid && b.last;
            if (b.valid) begin
               narrowRef(b.prod, pv, pc);
               start = b.first || mRestart;
               narrowRef((start ? 64'sd0 : mAcc) + pv, sv, sc);
               mSticky  = (!start && mSticky) || pc || sc;
               mAcc     = sv;
               mRestart = b.last;
               if (b.last) begin
                  expAccDout = sv;
                  expAccSat  = mSticky;
               end
            end
         end
         while (hist.size() > NS + 1)
            void'(hist.pop_front());
      end
   end

   always @(negedge ap_clk) begin
      if (checkEn) begin
         checkOutput("mul_valid", mulValid, expMulValid);
         if (expMulValid)
            checkOutput("mul_dout", $signed(mulDout), expMulDout);
         checkOutput("mul_last", mulLast, 0);
         checkOutput("acc_valid", accValid, expAccValid);
         checkOutput("acc_last", accLast, expAccValid);
         checkOutput("acc_dout", $signed(accDout), expAccDout);
`ifdef TOP_FDCT_MAC_SAT_EN
         if (expMulValid)
            checkOutput("mul_sat", mulSat, expMulSat);
         checkOutput("acc_sat", accSat, expAccSat);
`endif
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int     pulses;
      longint lastVal;
      bit     lastCe;
      bit     stall;
      int     beat;

      vecCount  = 0;
      missCount = 0;
      checkEn   = 1'b0;
      ap_rst_n  = 1'b0;
      ce        = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      din0      = '0;
      din1      = '0;

      // Reset must act even with ce low.
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      checkOutput("rst_mul_valid", mulValid, 0);
      checkOutput("rst_mul_dout", $signed(mulDout), 0);
      checkOutput("rst_acc_valid", accValid, 0);
      checkOutput("rst_acc_last", accLast, 0);
      checkOutput("rst_acc_dout", $signed(accDout), 0);
      checkEn  = 1'b1;
      ap_rst_n = 1'b1;
      ce       = 1'b1;

      // Single signed x unsigned product and its two-cycle latency.
      applyStimulus(1'b1, 16'hFFFD, 13'd8191, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_early", mulValid, 0);
      applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_valid", mulValid, 1);
      checkOutput("t1_dout", $signed(mulDout), -24573);
      applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_pulse_end", mulValid, 0);

      // Back-to-back squares.
      for (int k = 0; k < 10; k++) begin
         applyStimulus(k < 8, 16'(k), 13'(k), 1'b0, 1'b0, 1'b1);
         if (k >= 2) begin
            checkOutput("t2_valid", mulValid, 1);
            checkOutput("t2_dout", $signed(mulDout), (k - 2) * (k - 2));
         end
      end

      // Dot product 1..8 x 100, one result three cycles after the last beat.
      for (int k = 0; k < 12; k++) begin
         applyStimulus(k < 8, 16'(k + 1), 13'd100, k == 0, k == 7, 1'b1);
         if (k == 9)
            checkOutput("t3_early", accValid, 0);
         if (k == 10) begin
            checkOutput("t3_valid", accValid, 1);
            checkOutput("t3_last", accLast, 1);
            checkOutput("t3_sum", $signed(accDout), 3600);
         end
         if (k == 11)
            checkOutput("t3_pulse_end", accValid, 0);
      end

      // Same sum with a three-cycle ce stall carrying junk that must be ignored.
      beat   = 0;
      pulses = 0;
      lastVal = 0;
      for (int s = 0; s < 20; s++) begin
         lastCe = ce;
         stall  = (s >= 4) && (s < 7);
         if (stall)
            applyStimulus(1'b1, 16'($urandom), 13'($urandom), 1'b1, 1'b1, 1'b0);
         else if (beat < 8) begin
            applyStimulus(1'b1, 16'(beat + 1), 13'd100, beat == 0, beat == 7, 1'b1);
            beat++;
         end else
            applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);
         if (lastCe && accValid) begin
            pulses++;
            lastVal = longint'($signed(accDout));
         end
      end
      checkOutput("t4_pulses", pulses, 1);
      checkOutput("t4_sum", lastVal, 3600);

      // Reset in the middle of a sum discards it; a fresh two-beat sum follows.
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 16'(k + 1), 13'd100, k == 0, 1'b0, 1'b1);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      checkOutput("t5_mul_valid", mulValid, 0);
      checkOutput("t5_acc_valid", accValid, 0);
      checkOutput("t5_acc_dout", $signed(accDout), 0);
      applyStimulus(1'b1, 16'd2, 13'd5, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'd2, 13'd5, 1'b0, 1'b1, 1'b1);
      countPulses(8, pulses, lastVal);
      checkOutput("t5_pulses", pulses, 1);
      checkOutput("t5_sum", lastVal, 20);

      // Eight maximal products overflow the accumulator range.
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b1, 16'd32767, 13'd8191, k == 0, k == 7, 1'b1);
      countPulses(6, pulses, lastVal);
      checkOutput("t6_pulses", pulses, 1);
`ifdef TOP_FDCT_MAC_SAT_EN
      checkOutput("t6_sum", lastVal, 268435455);
      checkOutput("t6_sat_flag", accSat, 1);
`else
      checkOutput("t6_sum", lastVal, -327672);
`endif

      // Random beats, tags, stalls and occasional resets against the model.
      for (int n = 0; n < 500; n++) begin
         applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 13'($urandom),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) != 0);
         ap_rst_n = ($urandom_range(0, 99) != 0);
      end
      ap_rst_n = 1'b1;
      repeat (6) applyStimulus(1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1);

      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
